// File: rtl/traducaoendereco.sv
// Physical-to-logical address translation: recovers process index and block offset
// by repeated subtraction of the block size, one step per clock.
module traducaoendereco #(
  parameter logic [31:0] TAM_BLOCO = 32'd300,
  parameter int unsigned NUM_PROC  = 8,
  parameter int unsigned PROC_W    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       endFisico,
  output logic              busy,
  output logic              done,
  output logic [PROC_W-1:0] processoId,
  output logic [31:0]       endLogico,
  output logic              foraFaixa
);

  typedef enum logic {IDLE, SUB} state_t;

  localparam logic [PROC_W-1:0] LAST_CNT = PROC_W'(NUM_PROC - 1);

  state_t              state_q, state_d;
  logic [31:0]         rem_q, rem_d;
  logic [PROC_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PROC_W-1:0]   id_q, id_d;
  logic [31:0]         log_q, log_d;
  logic                fora_q, fora_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= '0;
      log_q   <= '0;
      fora_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      id_q    <= id_d;
      log_q   <= log_d;
      fora_q  <= fora_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    id_d    = id_q;
    log_d   = log_q;
    fora_d  = fora_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = endFisico;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        // Remainder check wins over the range check so the last block still resolves.
        if (rem_q < TAM_BLOCO) begin
          id_d    = cnt_q;
          log_d   = rem_q;
          fora_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          id_d    = '0;
          log_d   = '0;
          fora_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rem_d = rem_q - TAM_BLOCO;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign processoId = id_q;
  assign endLogico  = log_q;
  assign foraFaixa  = fora_q;

endmodule

// File: doc/traducaoendereco.md
Name: traducaoEndereco

Overview:
- Inverse of the branch-correction path: takes a physical (relocated) address and recovers the owning process index and the process-relative logical address.
- Used by the OS-support logic and the debug/trap path to report a faulting PC in process-local form.
- Divides by the block size through iterative subtraction (one subtraction per clock), so no hardware divider is needed.
- Uses a start/busy/done handshake and flags addresses beyond the last process block.

Parameters:
- TAM_BLOCO, 32'd300, instruction-memory block size per process. Must be the same value used by the forward correction path.
- NUM_PROC, 8, number of process blocks in memory.
- PROC_W, 3, width of the process index; must be at least clog2(NUM_PROC).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- endFisico  input  32  physical address to translate; sampled on the start edge only.
- busy  output  1  high while a translation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- processoId  output  PROC_W  recovered process index.
- endLogico  output  32  recovered logical address (endFisico mod TAM_BLOCO).
- foraFaixa  output  1  set when endFisico >= NUM_PROC*TAM_BLOCO.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, processoId=0, endLogico=0, foraFaixa=0; internal remainder and counter cleared. An in-flight translation is abandoned and no done is produced for it.
- States: IDLE, SUB.
- IDLE:
  - done deasserts; all result outputs hold their last values.
  - On a rising edge with start=1: rem <= endFisico, cnt <= 0, busy <= 1, state <= SUB.
- SUB, evaluated every edge in priority order:
  1. rem < TAM_BLOCO: processoId <= cnt, endLogico <= rem, foraFaixa <= 0, done <= 1, busy <= 0, state <= IDLE.
  2. Else if cnt == NUM_PROC-1: processoId <= 0, endLogico <= 0, foraFaixa <= 1, done <= 1, busy <= 0, state <= IDLE.
  3. Else: rem <= rem - TAM_BLOCO, cnt <= cnt + 1.
- done is registered, high for exactly one cycle, and always coincides with the update of processoId, endLogico and foraFaixa.
- Latency: for an address in block k (0 <= k < NUM_PROC), done is high after edge k+1, where edge 0 is the edge that samples start.
- Out-of-range address: done and foraFaixa go high after edge NUM_PROC.
- start while busy=1 is ignored. endFisico changes during a translation have no effect.
- start in the same cycle that done is high is accepted, because the state is already IDLE on that edge.
- Arithmetic:
  - All unsigned 32-bit.
  - The subtraction only happens when rem >= TAM_BLOCO, so it never underflows.
  - cnt never exceeds NUM_PROC-1, so it never wraps.
- Exact block boundaries: address j*TAM_BLOCO maps to processoId=j, endLogico=0. Address j*TAM_BLOCO-1 maps to processoId=j-1, endLogico=TAM_BLOCO-1.
- endFisico=32'hFFFFFFFF must flag foraFaixa after NUM_PROC edges without overflow.

Test Plan:
- Reset held, then released with start=0 -> all outputs 0, busy=0, and state stays IDLE for 10 cycles.
- start with endFisico=0 -> done after edge 1: processoId=0, endLogico=0, foraFaixa=0. Then start with endFisico=299 -> processoId=0, endLogico=299.
- endFisico=650 -> busy high for 3 cycles; done after edge 3: processoId=2, endLogico=50. Then endFisico=300 -> done after edge 2: processoId=1, endLogico=0.
- endFisico=2399 -> done after edge 8: processoId=7, endLogico=299. Then endFisico=2400, and separately 32'hFFFFFFFF -> each gives done after edge 8 with foraFaixa=1, processoId=0, endLogico=0.
- Busy/back-to-back handshake:
  - endFisico=1000 is started, then start pulses again with endFisico=10 while busy -> the second start is ignored; result is processoId=3, endLogico=100.
  - start held high through the done cycle with endFisico=10 -> a new translation begins immediately; its done gives processoId=0, endLogico=10.
- Reset mid-operation: start with endFisico=2000 and assert reset after edge 3 -> busy=0 and all outputs 0 immediately, with no done pulse. After release, endFisico=900 -> processoId=3, endLogico=0.
